// File: rtl/tour_seq_pkg.sv
// Shared types and constants for the tour command sequencer: FSM states,
// error codes and the Knight command opcode/heading encodings.
package tour_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_SNT,
        ST_WAIT_RESP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_NACK     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OFFBOARD = 2'd3;

    localparam logic [3:0] MOVE         = 4'h4;
    localparam logic [3:0] MOVE_FANFARE = 4'h5;
    localparam logic [3:0] CAL          = 4'h2;

    localparam logic [7:0] NORTH = 8'h00;
    localparam logic [7:0] WEST  = 8'h3F;
    localparam logic [7:0] SOUTH = 8'h7F;
    localparam logic [7:0] EAST  = 8'hBF;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH x WIDTH storage, read data taken from the registered read
// pointer, pushes while full are dropped, flush empties it in one cycle.
module cmd_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign rd_data = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers simply wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Queues Knight commands and issues them one at a time to RemoteComm, stopping
// on a negative ack or response timeout. Define TOUR_POS_CHECK_EN for position tracking.
module tour_cmd_sequencer
    import tour_seq_pkg::*;
#(
    parameter int         DEPTH   = 16,
    parameter int         TMO_W   = 26,
    parameter logic [7:0] POS_ACK = 8'hA5
`ifdef TOUR_POS_CHECK_EN
    ,
    parameter logic [2:0] X0 = 3'h2,
    parameter logic [2:0] Y0 = 3'h2
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [15:0]                push_cmd,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    input  logic                       start,
    input  logic                       abort,
    output logic [15:0]                cmd,
    output logic                       snd_cmd,
    input  logic                       cmd_snt,
    input  logic                       resp_rdy,
    input  logic [7:0]                 resp,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [7:0]                 acked
`ifdef TOUR_POS_CHECK_EN
    ,
    output logic [2:0]                 exp_xx,
    output logic [2:0]                 exp_yy
`endif
);

    // The counter becomes all-ones on the edge that ends the cycle holding this value.
    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_t      state;
    state_t      state_nxt;
    logic [TMO_W-1:0] tmo_cnt;
    logic        tmo_hit;
    logic        resp_pos;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_empty;
    logic [15:0] fifo_rd_data;
    logic        off_board;

    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign resp_pos = resp_rdy && (resp == POS_ACK);
    assign fifo_push = push && !busy;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (abort),
        .wr_data (push_cmd),
        .rd_data (fifo_rd_data),
        .full    (full),
        .empty   (fifo_empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start && !fifo_empty) state_nxt = ST_LOAD;
                ST_LOAD:      state_nxt = off_board ? ST_ERR : ST_SEND;
                ST_SEND:      state_nxt = ST_WAIT_SNT;
                ST_WAIT_SNT:  if (cmd_snt) state_nxt = ST_WAIT_RESP;
                ST_WAIT_RESP: begin
                    if (resp_rdy) begin
                        if (resp_pos) state_nxt = fifo_empty ? ST_DONE : ST_LOAD;
                        else          state_nxt = ST_ERR;
                    end else if (tmo_hit) begin
                        state_nxt = ST_ERR;
                    end
                end
                ST_DONE:      state_nxt = ST_IDLE;
                ST_ERR:       state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state == ST_LOAD) || (state == ST_SEND) ||
                   (state == ST_WAIT_SNT) || (state == ST_WAIT_RESP);
        done     = (state == ST_DONE);
        snd_cmd  = (state == ST_SEND) && !abort;
        fifo_pop = (state == ST_LOAD) && !abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd      <= '0;
            tmo_cnt  <= '0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            acked    <= '0;
        end else if (abort) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !fifo_empty) begin
                        err      <= 1'b0;
                        err_code <= ERR_NONE;
                        acked    <= '0;
                    end
                end
                ST_LOAD: begin
                    cmd <= fifo_rd_data;
                    if (off_board) begin
                        err      <= 1'b1;
                        err_code <= ERR_OFFBOARD;
                    end
                end
                ST_WAIT_SNT: begin
                    if (cmd_snt) tmo_cnt <= '0;
                end
                ST_WAIT_RESP: begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                    if (resp_rdy) begin
                        if (resp_pos) begin
                            if (acked != 8'hFF) acked <= acked + 8'd1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_NACK;
                        end
                    end else if (tmo_hit) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TOUR_POS_CHECK_EN
    logic signed [3:0] new_x;
    logic signed [3:0] new_y;
    logic signed [3:0] squares;
    logic [2:0]        pend_x;
    logic [2:0]        pend_y;

    // Candidate position for the command at the FIFO head, in 4-bit signed arithmetic.
    always_comb begin
        new_x   = signed'({1'b0, exp_xx});
        new_y   = signed'({1'b0, exp_yy});
        squares = signed'(fifo_rd_data[3:0]);
        if ((fifo_rd_data[15:12] == MOVE) || (fifo_rd_data[15:12] == MOVE_FANFARE)) begin
            case (fifo_rd_data[11:4])
                NORTH:   new_y = new_y + squares;
                SOUTH:   new_y = new_y - squares;
                WEST:    new_x = new_x - squares;
                EAST:    new_x = new_x + squares;
                default: ;
            endcase
        end
    end

    assign off_board = (state == ST_LOAD) &&
                       ((new_x < 4'sd0) || (new_x > 4'sd4) ||
                        (new_y < 4'sd0) || (new_y > 4'sd4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_xx <= X0;
            exp_yy <= Y0;
            pend_x <= X0;
            pend_y <= Y0;
        end else if (!abort) begin
            if (state == ST_LOAD) begin
                pend_x <= new_x[2:0];
                pend_y <= new_y[2:0];
            end else if ((state == ST_WAIT_RESP) && resp_pos) begin
                exp_xx <= pend_x;
                exp_yy <= pend_y;
            end
        end
    end
`else
    assign off_board = 1'b0;
`endif

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Self-checking bench for tour_cmd_sequencer: table of single-command transactions
// plus hand-written sequences for multi-command, nack resume, timeout and abort.
module tb_tour_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO_W = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          push;
    logic [15:0]   push_cmd;
    logic          full;
    logic [CW-1:0] count;
    logic          start;
    logic          abort;
    logic [15:0]   cmd;
    logic          snd_cmd;
    logic          cmd_snt;
    logic          resp_rdy;
    logic [7:0]    resp;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [7:0]    acked;
`ifdef TOUR_POS_CHECK_EN
    logic [2:0]    exp_xx;
    logic [2:0]    exp_yy;
`endif

    tour_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TMO_W   (TMO_W),
        .POS_ACK (8'hA5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_cmd (push_cmd),
        .full     (full),
        .count    (count),
        .start    (start),
        .abort    (abort),
        .cmd      (cmd),
        .snd_cmd  (snd_cmd),
        .cmd_snt  (cmd_snt),
        .resp_rdy (resp_rdy),
        .resp     (resp),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .acked    (acked)
`ifdef TOUR_POS_CHECK_EN
        ,
        .exp_xx   (exp_xx),
        .exp_yy   (exp_yy)
`endif
    );

    typedef struct {
        logic [15:0] cmd_word;
        logic [7:0]  resp_byte;
        logic        exp_done;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [7:0]  exp_acked;
    } vec_t;

    vec_t        vecs [6];
    int          n_cmp;
    int          n_fail;
    logic [15:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Every snd_cmd pulse must carry the oldest command still owed to RemoteComm.
    always @(negedge clk) begin
        if (rst_n && snd_cmd === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_snd: got cmd 0x%0h, expected no request at %0t", cmd, $time);
            end else begin
                checkOutput("sent_cmd", {16'h0, cmd}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushCmd(input logic [15:0] c, input bit will_send);
        push     = 1'b1;
        push_cmd = c;
        if (will_send) exp_q.push_back(c);
        step();
        push     = 1'b0;
        push_cmd = '0;
    endtask

    task automatic startSeq();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic waitSnd();
        int i;
        for (i = 0; i < 20; i++) begin
            if (snd_cmd === 1'b1) break;
            step();
        end
        if (i == 20) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL snd_wait: got no snd_cmd, expected one within 20 cycles");
        end
    endtask

    // Plays RemoteComm from the SEND cycle: cmd_snt after a short UART delay, then a response.
    task automatic completeCmd(input logic [7:0] b, input int gap);
        step();
        step();
        cmd_snt = 1'b1;
        step();
        cmd_snt = 1'b0;
        repeat (gap) step();
        resp_rdy = 1'b1;
        resp     = b;
        step();
        resp_rdy = 1'b0;
        resp     = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        pushCmd(v.cmd_word, 1'b1);
        startSeq();
        waitSnd();
        completeCmd(v.resp_byte, 2);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        push     = 1'b0;
        push_cmd = '0;
        start    = 1'b0;
        abort    = 1'b0;
        cmd_snt  = 1'b0;
        resp_rdy = 1'b0;
        resp     = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        checkOutput("rst_full",     {31'h0, full},     32'h0);
        checkOutput("rst_count",    {29'h0, count},    32'h0);
        checkOutput("rst_snd",      {31'h0, snd_cmd},  32'h0);
        checkOutput("rst_busy",     {31'h0, busy},     32'h0);
        checkOutput("rst_done",     {31'h0, done},     32'h0);
        checkOutput("rst_err",      {31'h0, err},      32'h0);
        checkOutput("rst_err_code", {30'h0, err_code}, 32'h0);
        checkOutput("rst_acked",    {24'h0, acked},    32'h0);
        checkOutput("rst_cmd",      {16'h0, cmd},      32'h0);

        vecs[0] = '{16'h2000, 8'hA5, 1'b1, 1'b0, 2'd0, 8'd1};
        vecs[1] = '{16'h53F4, 8'hA5, 1'b1, 1'b0, 2'd0, 8'd1};
        vecs[2] = '{16'h47F1, 8'h5A, 1'b0, 1'b1, 2'd1, 8'd0};
        vecs[3] = '{16'h1234, 8'hA5, 1'b1, 1'b0, 2'd0, 8'd1};
        vecs[4] = '{16'h5BF4, 8'h00, 1'b0, 1'b1, 2'd1, 8'd0};
        vecs[5] = '{16'hFFFF, 8'hA4, 1'b0, 1'b1, 2'd1, 8'd0};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_done", i),     {31'h0, done},     {31'h0, vecs[i].exp_done});
            checkOutput($sformatf("v%0d_err", i),      {31'h0, err},      {31'h0, vecs[i].exp_err});
            checkOutput($sformatf("v%0d_err_code", i), {30'h0, err_code}, {30'h0, vecs[i].exp_code});
            checkOutput($sformatf("v%0d_acked", i),    {24'h0, acked},    {24'h0, vecs[i].exp_acked});
            checkOutput($sformatf("v%0d_busy", i),     {31'h0, busy},     32'h0);
            step();
        end

        // Three queued moves, checking the 2-cycle start/resp_rdy to snd_cmd latency.
        pushCmd(16'h53F4, 1'b1);
        pushCmd(16'h47F1, 1'b1);
        pushCmd(16'h5BF4, 1'b1);
        checkOutput("multi_count", {29'h0, count}, 32'd3);
        startSeq();
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("multi%0d_lat_lo", k), {31'h0, snd_cmd}, 32'h0);
            step();
            checkOutput($sformatf("multi%0d_lat_hi", k), {31'h0, snd_cmd}, 32'h1);
            completeCmd(8'hA5, 1 + k);
        end
        checkOutput("multi_done",  {31'h0, done},  32'h1);
        checkOutput("multi_acked", {24'h0, acked}, 32'd3);
        checkOutput("multi_err",   {31'h0, err},   32'h0);
        step();
        checkOutput("multi_done_pulse", {31'h0, done}, 32'h0);

        // Negative ack keeps the remaining entry; the next start sends it.
        pushCmd(16'h2101, 1'b1);
        pushCmd(16'h2202, 1'b1);
        startSeq();
        waitSnd();
        completeCmd(8'h5A, 0);
        checkOutput("nack_err",      {31'h0, err},      32'h1);
        checkOutput("nack_err_code", {30'h0, err_code}, 32'd1);
        checkOutput("nack_count",    {29'h0, count},    32'd1);
        checkOutput("nack_busy",     {31'h0, busy},     32'h0);
        step();
        checkOutput("nack_sticky", {31'h0, err}, 32'h1);
        startSeq();
        checkOutput("resume_err_clr",  {31'h0, err},      32'h0);
        checkOutput("resume_code_clr", {30'h0, err_code}, 32'h0);
        waitSnd();
        completeCmd(8'hA5, 1);
        checkOutput("resume_done",  {31'h0, done},  32'h1);
        checkOutput("resume_acked", {24'h0, acked}, 32'd1);
        step();

        // Response timeout: ERR exactly 255 cycles after cmd_snt.
        pushCmd(16'h3003, 1'b1);
        startSeq();
        waitSnd();
        step();
        step();
        cmd_snt = 1'b1;
        step();
        cmd_snt = 1'b0;
        repeat (254) step();
        checkOutput("tmo_early_err",  {31'h0, err},  32'h0);
        checkOutput("tmo_early_busy", {31'h0, busy}, 32'h1);
        step();
        checkOutput("tmo_err",      {31'h0, err},      32'h1);
        checkOutput("tmo_err_code", {30'h0, err_code}, 32'd2);
        checkOutput("tmo_busy",     {31'h0, busy},     32'h0);
        step();

        // resp_rdy in the very cycle the counter saturates still counts as an ack.
        pushCmd(16'h3004, 1'b1);
        startSeq();
        waitSnd();
        step();
        step();
        cmd_snt = 1'b1;
        step();
        cmd_snt = 1'b0;
        repeat (254) step();
        resp_rdy = 1'b1;
        resp     = 8'hA5;
        step();
        resp_rdy = 1'b0;
        resp     = '0;
        checkOutput("tmo_race_err",   {31'h0, err},   32'h0);
        checkOutput("tmo_race_done",  {31'h0, done},  32'h1);
        checkOutput("tmo_race_acked", {24'h0, acked}, 32'd1);
        step();

        // Fill past DEPTH, then abort in WAIT_RESP.
        pushCmd(16'h4100, 1'b1);
        pushCmd(16'h4200, 1'b0);
        pushCmd(16'h4300, 1'b0);
        pushCmd(16'h4400, 1'b0);
        checkOutput("fill_full",  {31'h0, full},  32'h1);
        checkOutput("fill_count", {29'h0, count}, 32'd4);
        pushCmd(16'h4500, 1'b0);
        checkOutput("over_full",  {31'h0, full},  32'h1);
        checkOutput("over_count", {29'h0, count}, 32'd4);
        startSeq();
        pushCmd(16'h4600, 1'b0);
        checkOutput("busy_push_count", {29'h0, count}, 32'd3);
        waitSnd();
        step();
        step();
        cmd_snt = 1'b1;
        step();
        cmd_snt = 1'b0;
        step();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_busy",  {31'h0, busy},  32'h0);
        checkOutput("abort_count", {29'h0, count}, 32'd0);
        checkOutput("abort_full",  {31'h0, full},  32'h0);
        checkOutput("abort_err",   {31'h0, err},   32'h0);
        resp_rdy = 1'b1;
        resp     = 8'hA5;
        step();
        resp_rdy = 1'b0;
        resp     = '0;
        checkOutput("late_resp_done",  {31'h0, done},  32'h0);
        checkOutput("late_resp_acked", {24'h0, acked}, 32'd0);
        checkOutput("late_resp_err",   {31'h0, err},   32'h0);
        startSeq();
        checkOutput("empty_start_busy", {31'h0, busy}, 32'h0);
        repeat (3) step();

        checkOutput("sb_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
